// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg : shared digit types and BCD limits for the cook timer
// Rev 1.0
// ============================================================================
package timer_pkg;

    localparam int         DIGIT_W      = 4;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
    } bcd_time_t;

    function automatic logic is_digit(input digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : divides the clock down to a one-second tick
// Rev 1.0
// ============================================================================
module timer_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic clear,
    input  logic flush_i,
    input  logic count_i,
    output logic tick_o
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = count_i && !flush_i && (cnt_q == TERMINAL);

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer.sv
`default_nettype none
// ============================================================================
// timer : four-digit BCD MM:SS cook timer with keypad shift-in and countdown
// Rev 1.0
// ============================================================================
module timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [3:0]   data_in,
    input  logic         loadn,
    input  logic         enable,
    output logic [3:0]   sec_ones,
    output logic [3:0]   sec_tens,
    output logic [3:0]   min_ones,
    output logic [3:0]   min_tens,
    output logic         zero,
    output logic         done
);

    bcd_time_t time_q;
    bcd_time_t time_d;
    logic      done_q;
    logic      done_d;
    logic      tick;
    logic      zero_w;

    assign zero_w = (time_q == '0);

    // Prescaler stays flushed while loading or parked at 00:00.
    timer_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .clear   (clear),
        .flush_i (!loadn || zero_w),
        .count_i (loadn && enable && !zero_w),
        .tick_o  (tick)
    );

    always_comb begin
        time_d = time_q;
        done_d = 1'b0;
        if (!loadn) begin
            if (is_digit(data_in)) begin
                time_d = {time_q.min_ones, time_q.sec_tens, time_q.sec_ones, data_in};
            end
        end else if (tick) begin
            if (time_q.sec_ones != 4'd0) begin
                time_d.sec_ones = time_q.sec_ones - 4'd1;
            end else begin
                time_d.sec_ones = BCD_MAX;
                if (time_q.sec_tens != 4'd0) begin
                    time_d.sec_tens = time_q.sec_tens - 4'd1;
                end else begin
                    time_d.sec_tens = SEC_TENS_MAX;
                    if (time_q.min_ones != 4'd0) begin
                        time_d.min_ones = time_q.min_ones - 4'd1;
                    end else begin
                        time_d.min_ones = BCD_MAX;
                        time_d.min_tens = time_q.min_tens - 4'd1;
                    end
                end
            end
            done_d = (time_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            time_q <= '0;
            done_q <= 1'b0;
        end else begin
            time_q <= time_d;
            done_q <= done_d;
        end
    end

    assign sec_ones = time_q.sec_ones;
    assign sec_tens = time_q.sec_tens;
    assign min_ones = time_q.min_ones;
    assign min_tens = time_q.min_tens;
    assign zero     = zero_w;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
// tb_timer : randomized and directed bench for timer against an MM:SS model
// Rev 1.0
// ============================================================================
module tb_timer;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       clear, loadn, enable;
    logic [3:0] data_in;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       zero, done;

    int n_vec = 0;
    int n_err = 0;
    int done_seen;

    // Reference state: minutes and seconds as plain integers.
    int m_mm = 0, m_ss = 0, m_pre = 0;
    bit m_done = 1'b0;

    timer #(.TICK_DIV(TD)) dut (
        .clock    (clock),
        .clear    (clear),
        .data_in  (data_in),
        .loadn    (loadn),
        .enable   (enable),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .zero     (zero),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_val();
        return {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    endfunction

    function automatic logic [15:0] dut_val();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic model_edge();
        int v;
        bit z;
        z = (m_mm == 0 && m_ss == 0);
        if (clear) begin
            m_mm = 0; m_ss = 0; m_pre = 0; m_done = 1'b0;
        end else if (!loadn) begin
            m_done = 1'b0;
            m_pre  = 0;
            if (data_in <= 4'd9) begin
                v    = ((m_mm * 100 + m_ss) * 10 + int'(data_in)) % 10000;
                m_mm = v / 100;
                m_ss = v % 100;
            end
        end else if (enable && !z) begin
            m_done = 1'b0;
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (m_ss > 0) m_ss--;
                else begin
                    m_ss = 59;
                    m_mm--;
                end
                m_done = (m_mm == 0 && m_ss == 0);
            end else begin
                m_pre++;
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic step(input logic c, input logic ld_n, input logic en, input logic [3:0] d);
        @(negedge clock);
        clear = c; loadn = ld_n; enable = en; data_in = d;
        @(posedge clock);
        model_edge();
        #1;
        check("value", dut_val(), model_val());
        check("zero", {15'd0, zero}, {15'd0, (m_mm == 0 && m_ss == 0)});
        check("done", {15'd0, done}, {15'd0, m_done});
        if (done) done_seen++;
    endtask

    task automatic load4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b0, 1'b0, v[i*4 +: 4]);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, en, 4'd0);
    endtask

    initial begin
        clear = 1'b1; loadn = 1'b1; enable = 1'b0; data_in = 4'd0;
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("reset_val", dut_val(), 16'h0000);

        // Clear after arbitrary state
        for (int i = 0; i < 30; i++)
            step(1'b0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        step(1'b1, 1'b1, 1'b1, 4'd0);
        check("clear_val", dut_val(), 16'h0000);

        // Keypad shift-in and invalid digit rejection
        step(1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("load_0130", dut_val(), 16'h0130);
        step(1'b0, 1'b0, 1'b0, 4'hC);
        check("load_bad_digit", dut_val(), 16'h0130);

        // 00:05 countdown, single done pulse, then parked at 00:00
        step(1'b1, 1'b1, 1'b0, 4'd0);
        load4(16'h0005);
        done_seen = 0;
        run(5 * TD + 40, 1'b1);
        check("done_count", 16'(done_seen), 16'd1);
        check("parked", dut_val(), 16'h0000);

        // Minute and ten-minute borrows
        load4(16'h0100);
        run(TD, 1'b1);
        check("borrow_min", dut_val(), 16'h0059);
        load4(16'h1000);
        run(TD, 1'b1);
        check("borrow_tens", dut_val(), 16'h0959);

        // Pause mid-second and resume with same phase
        load4(16'h0010);
        run(TD + 2, 1'b1);
        run(20, 1'b0);
        run(3 * TD, 1'b1);

        // Clear mid-count, then load mid-count
        load4(16'h0007);
        run(2 * TD + 1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'd0);
        check("clear_mid", {15'd0, done}, 16'd0);
        load4(16'h0012);
        run(TD - 1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd3);
        check("load_mid", dut_val(), 16'h0123);
        load4(16'h0075);
        run(20 * TD, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 15) != 0),
                 1'($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
